// File: rtl/l2_input_sched.sv
// l2_input_sched: per-decode arbitration of flush, response, forward, sweep and CPU work
// for the L2 pipeline, with a set/way flush sweep and CPU anti-starvation.
module l2_input_sched #(
    parameter int ADDR_BITS   = 32,
    parameter int W_OFF_BITS  = 2,
    parameter int B_OFF_BITS  = 2,
    parameter int L2_SET_BITS = 9,
    parameter int L2_WAYS     = 8,
    parameter int N_MSHR      = 4,
    parameter int STARVE_MAX  = 15
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic                                                    decode_en,
    input  logic                                                    flush_valid,
    output logic                                                    flush_ready,
    input  logic                                                    rsp_valid,
    output logic                                                    rsp_ready,
    input  logic [ADDR_BITS-W_OFF_BITS-B_OFF_BITS-1:0]              rsp_addr,
    input  logic                                                    fwd_valid,
    output logic                                                    fwd_ready,
    input  logic [ADDR_BITS-W_OFF_BITS-B_OFF_BITS-1:0]              fwd_addr,
    input  logic                                                    cpu_req_valid,
    output logic                                                    cpu_req_ready,
    input  logic [ADDR_BITS-1:0]                                    cpu_req_addr,
    input  logic [$clog2(N_MSHR+1)-1:0]                             mshr_free,
    input  logic                                                    fwd_stall,
    input  logic                                                    fwd_stall_ended,
    input  logic                                                    set_conflict,
    input  logic                                                    evict_stall,
    input  logic                                                    ongoing_atomic,
    output logic                                                    set_fwd_in_from_stalled,
    output logic                                                    set_cpu_req_from_conflict,
    output logic                                                    do_flush,
    output logic                                                    do_rsp,
    output logic                                                    do_fwd,
    output logic                                                    do_flush_way,
    output logic                                                    do_cpu_req,
    output logic                                                    idle,
    output logic [L2_SET_BITS-1:0]                                  flush_set,
    output logic [$clog2(L2_WAYS)-1:0]                              flush_way,
    output logic                                                    flush_done,
    output logic [ADDR_BITS-W_OFF_BITS-B_OFF_BITS-L2_SET_BITS-1:0]  line_tag,
    output logic [L2_SET_BITS-1:0]                                  line_set,
    output logic [ADDR_BITS-1:0]                                    req_line,
    output logic [ADDR_BITS-W_OFF_BITS-B_OFF_BITS-L2_SET_BITS-1:0]  req_tag,
    output logic [L2_SET_BITS-1:0]                                  req_set,
    output logic [W_OFF_BITS-1:0]                                   req_w_off,
    output logic [B_OFF_BITS-1:0]                                   req_b_off
);
    localparam int OFFSET_BITS = W_OFF_BITS + B_OFF_BITS;
    localparam int LINE_BITS   = ADDR_BITS - OFFSET_BITS;
    localparam int L2_SETS     = 2 ** L2_SET_BITS;
    localparam int WAY_BITS    = $clog2(L2_WAYS);
    localparam int MC_BITS     = $clog2(N_MSHR + 1);
    localparam int SC_BITS     = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] F_IDLE  = 2'd0;
    localparam logic [1:0] F_SWEEP = 2'd1;
    localparam logic [1:0] F_DONE  = 2'd2;

    logic [1:0]             fsm;
    logic [L2_SET_BITS-1:0] set;
    logic [WAY_BITS-1:0]    way;
    logic [SC_BITS-1:0]     starve_cnt;

    logic act, mfull, mnone, starved;
    logic el_f, el_r, el_w, el_s, el_c;
    logic g_f, g_r, g_w, g_s, g_c, none, hi;
    logic last_way, last_set;
    logic [LINE_BITS-1:0] line_sel;

    always_comb begin
        act      = decode_en && !rst;
        mfull    = mshr_free == MC_BITS'(N_MSHR);
        mnone    = mshr_free == '0;
        starved  = starve_cnt == SC_BITS'(STARVE_MAX);
        el_f     = act && flush_valid && fsm == F_IDLE && mfull;
        el_r     = act && rsp_valid && !mfull;
        el_w     = act && ((fwd_valid && !fwd_stall) || fwd_stall_ended);
        el_s     = act && fsm == F_SWEEP && !fwd_valid && !mnone;
        el_c     = act && (cpu_req_valid || set_conflict) && !evict_stall &&
                   (!mnone || ongoing_atomic) && fsm == F_IDLE;
        hi       = el_f || el_r;
        g_f      = el_f;
        g_r      = el_r && !el_f;
        // A starved CPU request jumps ahead of forwards and sweep steps
        g_c      = el_c && !hi && (starved || !(el_w || el_s));
        g_w      = el_w && !hi && !(starved && el_c);
        g_s      = el_s && !hi && !el_w && !(starved && el_c);
        none     = !(el_f || el_r || el_w || el_s || el_c);
        last_way = way == WAY_BITS'(L2_WAYS - 1);
        last_set = set == L2_SET_BITS'(L2_SETS - 1);
        line_sel = g_r ? rsp_addr : g_w ? fwd_addr : '0;
        flush_ready               = g_f;
        rsp_ready                 = g_r;
        fwd_ready                 = g_w && !fwd_stall;
        set_fwd_in_from_stalled   = g_w && fwd_stall;
        cpu_req_ready             = g_c && !set_conflict;
        set_cpu_req_from_conflict = g_c && set_conflict;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm          <= F_IDLE;
            set          <= '0;
            way          <= '0;
            starve_cnt   <= '0;
            do_flush     <= 1'b0;
            do_rsp       <= 1'b0;
            do_fwd       <= 1'b0;
            do_flush_way <= 1'b0;
            do_cpu_req   <= 1'b0;
            idle         <= 1'b0;
            flush_set    <= '0;
            flush_way    <= '0;
            flush_done   <= 1'b0;
            line_tag     <= '0;
            line_set     <= '0;
            req_line     <= '0;
            req_tag      <= '0;
            req_set      <= '0;
            req_w_off    <= '0;
            req_b_off    <= '0;
        end else begin
            flush_done <= 1'b0;
            if (decode_en) begin
                do_flush     <= g_f;
                do_rsp       <= g_r;
                do_fwd       <= g_w;
                do_flush_way <= g_s;
                do_cpu_req   <= g_c;
                idle         <= none;
                flush_set    <= g_s ? set : '0;
                flush_way    <= g_s ? way : '0;
                line_tag     <= line_sel[LINE_BITS-1:L2_SET_BITS];
                line_set     <= line_sel[L2_SET_BITS-1:0];
                req_line     <= {cpu_req_addr[ADDR_BITS-1:OFFSET_BITS], OFFSET_BITS'(0)};
                req_tag      <= cpu_req_addr[ADDR_BITS-1:OFFSET_BITS+L2_SET_BITS];
                req_set      <= cpu_req_addr[OFFSET_BITS+L2_SET_BITS-1:OFFSET_BITS];
                req_w_off    <= cpu_req_addr[OFFSET_BITS-1:B_OFF_BITS];
                req_b_off    <= cpu_req_addr[B_OFF_BITS-1:0];
                starve_cnt   <= g_c ? '0 : (el_c && !starved) ? starve_cnt + SC_BITS'(1) : starve_cnt;
                if (fsm == F_IDLE && g_f) begin
                    fsm <= F_SWEEP;
                    set <= '0;
                    way <= '0;
                end else if (fsm == F_SWEEP && g_s) begin
                    way <= way + WAY_BITS'(1);
                    set <= last_way ? set + L2_SET_BITS'(1) : set;
                    fsm <= (last_way && last_set) ? F_DONE : F_SWEEP;
                end else if (fsm == F_DONE) begin
                    fsm        <= F_IDLE;
                    flush_done <= 1'b1;
                end
            end
        end
    end
endmodule
